// File: rtl/uart_mem_loader_if.sv
// Memory-write and status bundle driven by the UART memory loader.
interface uart_mem_loader_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        loading;
    logic        done;
    logic        frame_err;

    // Loader side drives the bundle.
    modport master (
        output mem_we, mem_addr, mem_wdata, loading, done, frame_err
    );

    // Memory / core side observes the bundle.
    modport slave (
        input mem_we, mem_addr, mem_wdata, loading, done, frame_err
    );
endinterface

// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver that assembles little-endian 32-bit words and writes
// WORD_COUNT of them to consecutive word addresses, holding the core in
// reset (loading) until the image is complete.
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_COUNT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    uart_mem_loader_if.master  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int WW = $clog2(WORD_COUNT + 1);

    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WORD_END = WW'(WORD_COUNT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [1:0]    byte_pos;
    logic [23:0]   word_buf;
    logic [WW-1:0] word_index;
    logic          full;
    logic          stop_tick;
    logic          byte_ok;
    logic          byte_bad;

    assign full      = (word_index == WORD_END);
    assign stop_tick = (state == STOP) && (baud_cnt == LAST_CLK);
    assign byte_ok   = stop_tick && rx_sync;
    assign byte_bad  = stop_tick && !rx_sync;

    // Two-flop synchronizer; flops reset to the idle line level.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM: start-bit qualification, data-bit timing, stop check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!rx_sync) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF_BIT) begin
                        baud_cnt <= '0;
                        state    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == LAST_CLK) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    if (baud_cnt == LAST_CLK) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Datapath shift registers: serial bits in, accepted bytes in.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; byte_pos and bit_idx decide when these hold
        // valid data, and every bit is overwritten before it is consumed.
        if (state == DATA && baud_cnt == LAST_CLK)
            shift_reg <= {rx_sync, shift_reg[7:1]};
        if (byte_ok && !full && byte_pos != 2'd3)
            word_buf <= {shift_reg, word_buf[23:8]};
    end

    // Word assembly and memory write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            byte_pos      <= '0;
            word_index    <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (byte_ok && !full) begin
                byte_pos <= byte_pos + 2'd1;
                if (byte_pos == 2'd3) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_wdata <= {shift_reg, word_buf};
                    bus.mem_addr  <= 32'({word_index, 2'b00});
                    word_index    <= word_index + WW'(1);
                end
            end
        end
    end

    // Status flags: completion lags the final write by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.loading   <= 1'b1;
            bus.done      <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.loading <= !full;
            bus.done    <= full;
            if (byte_bad) bus.frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each mem_we strobe.
module tb_uart_mem_loader;

    localparam int CPB = 8;
    localparam int WC  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_mem_loader_if bus ();

    uart_mem_loader #(
        .CLKS_PER_BIT (CPB),
        .WORD_COUNT   (WC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          we_cyc = -1;
    int          done_cyc = -1;
    logic        prev_we   = 1'b0;
    logic        prev_done = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor: compares every write strobe against the scoreboard queue.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.mem_we === 1'b1) begin
                check1("we_not_back_to_back", prev_we, 1'b0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", bus.mem_addr, e[63:32]);
                    check("write_data", bus.mem_wdata, e[31:0]);
                end
                we_cyc = cyc;
            end
            if (bus.done === 1'b1 && prev_done === 1'b0) done_cyc = cyc;
            prev_we   = bus.mem_we;
            prev_done = bus.done;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 8N1 frame, LSB first, followed by an idle gap long enough for the
    // receiver to reject the tail of a low stop bit as a false start.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            idle(1);
            k++;
        end
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        rx    = 1'b1;
        idle(3);
        check1({tag, "_rst_mem_we"}, bus.mem_we, 1'b0);
        check ({tag, "_rst_mem_addr"}, bus.mem_addr, 32'h0);
        check ({tag, "_rst_mem_wdata"}, bus.mem_wdata, 32'h0);
        check1({tag, "_rst_loading"}, bus.loading, 1'b1);
        check1({tag, "_rst_done"}, bus.done, 1'b0);
        check1({tag, "_rst_frame_err"}, bus.frame_err, 1'b0);
        reset = 1'b0;
        idle(2);
    endtask

    // Global watchdog so the run always reaches its summary.
    initial begin : watchdog
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stimulus
        logic [7:0] b;

        // Single word
        do_reset("por");
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_drain("word0");
        check1("word0_loading", bus.loading, 1'b1);
        check1("word0_done", bus.done, 1'b0);

        // Full image of two words, then a byte after completion
        do_reset("full");
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        exp_q.push_back({32'h0000_0004, 32'h0807_0605});
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_byte(b, 1'b1);
        end
        wait_drain("full");
        check1("full_done", bus.done, 1'b1);
        check1("full_loading", bus.loading, 1'b0);
        check("done_lag_cycles", 32'(done_cyc - we_cyc), 32'd1);
        send_byte(8'h09, 1'b1);
        idle(10);
        check("after_done_addr", bus.mem_addr, 32'h0000_0004);
        check("after_done_wdata", bus.mem_wdata, 32'h0807_0605);
        check1("after_done_done", bus.done, 1'b1);
        check1("after_done_loading", bus.loading, 1'b0);

        // Start-bit glitch, then a framing error, then a clean word
        do_reset("glitch");
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(30);
        check1("glitch_frame_err", bus.frame_err, 1'b0);
        check1("glitch_no_write", bus.mem_we, 1'b0);
        send_byte(8'hAA, 1'b0);
        check1("bad_stop_frame_err", bus.frame_err, 1'b1);
        exp_q.push_back({32'h0000_0000, 32'h4433_2211});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_drain("ferr");
        check1("frame_err_sticky", bus.frame_err, 1'b1);

        // Reset in the middle of a word and in the middle of a byte
        do_reset("pre_mid");
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        rx = 1'b0;
        idle(20);
        do_reset("mid");
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        wait_drain("mid");
        check1("mid_loading", bus.loading, 1'b1);
        check1("mid_done", bus.done, 1'b0);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
